// File: rtl/pc_counter_pkg.sv
// Shared types and defaults for the chunked program counter.
// States, default geometry and the chunk-count helper used by the incrementer.
package pc_counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam int PC_WIDTH_DEF = 32;
  localparam int PC_CHUNK_DEF = 8;
  localparam int PC_STEP_DEF  = 4;

  function automatic int nchunks(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_carry_select_inc.sv
// Combinational carry-select incrementer: a + STEP over WIDTH bits, CHUNK-bit slices.
// Only chunk 0 adds STEP; the upper chunks pick between themselves and themselves+1.
module chunk_carry_select_inc
  import pc_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int CHUNK = PC_CHUNK_DEF,
  parameter int STEP  = PC_STEP_DEF
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             NCH      = nchunks(WIDTH, CHUNK);
  localparam logic [CHUNK:0] STEP_EXT = (CHUNK + 1)'(STEP);
  localparam logic [CHUNK:0] ONE_EXT  = (CHUNK + 1)'(1);

  logic [CHUNK:0] w_chunk0;

  assign w_chunk0          = {1'b0, a[CHUNK-1:0]} + STEP_EXT;
  assign sum[CHUNK-1:0]    = w_chunk0[CHUNK-1:0];

  genvar gi;
  generate
    if (NCH == 1) begin : g_single
      assign cout = w_chunk0[CHUNK];
    end else begin : g_multi
      // w_cin[k] is the carry arriving at chunk k; it ripples only through the select chain.
      logic [NCH:1] w_cin;

      assign w_cin[1] = w_chunk0[CHUNK];

      for (gi = 1; gi < NCH; gi++) begin : g_chunk
        logic [CHUNK:0] w_inc;

        assign w_inc                   = {1'b0, a[gi*CHUNK +: CHUNK]} + ONE_EXT;
        assign sum[gi*CHUNK +: CHUNK]  = w_cin[gi] ? w_inc[CHUNK-1:0] : a[gi*CHUNK +: CHUNK];
        assign w_cin[gi+1]             = w_cin[gi] & w_inc[CHUNK];
      end

      assign cout = w_cin[NCH];
    end
  endgenerate

endmodule

// File: rtl/pc_counter_chunked.sv
// Front-end program counter with start/halt control, redirect and fetch handshake.
// Optional sticky misaligned-redirect flag under PC_COUNTER_MISALIGN_CHECK_EN.
module pc_counter_chunked
  import pc_counter_pkg::*;
#(
  parameter int               WIDTH    = PC_WIDTH_DEF,
  parameter int               CHUNK    = PC_CHUNK_DEF,
  parameter int               STEP     = PC_STEP_DEF,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             wrapped
`ifdef PC_COUNTER_MISALIGN_CHECK_EN
  ,
  output logic             misalign_err
`endif
);

  pc_state_t        r_state;
  pc_state_t        w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_pc_plus;
  logic             w_cout;
  logic             w_fire;
  logic             r_wrapped;
  logic             w_wrapped_next;

  chunk_carry_select_inc #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK),
    .STEP  (STEP)
  ) u_inc (
    .a    (r_pc),
    .sum  (w_pc_plus),
    .cout (w_cout)
  );

  // A redirect always wins over the advance; the accepted address was still the old pc.
  assign w_fire = (r_state == RUN) && out_ready && !ld_valid;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (halt) w_state_next = HALTED;
      end
      IDLE, HALTED: begin
        if (start && !halt) w_state_next = RUN;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_pc_next      = r_pc;
    w_wrapped_next = 1'b0;
    if (ld_valid) begin
      w_pc_next = ld_addr;
    end else if (w_fire) begin
      w_pc_next      = w_pc_plus;
      w_wrapped_next = w_cout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_wrapped <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_wrapped <= w_wrapped_next;
    end
  end

  assign out_valid = (r_state == RUN);
  assign pc        = r_pc;
  assign pc_plus   = w_pc_plus;
  assign wrapped   = r_wrapped;

`ifdef PC_COUNTER_MISALIGN_CHECK_EN
  // Alignment is only meaningful for power-of-two steps; other steps leave the mask empty.
  localparam bit               STEP_POW2 = (STEP > 0) && ((STEP & (STEP - 1)) == 0);
  localparam logic [WIDTH-1:0] MIS_MASK  = STEP_POW2 ? WIDTH'(STEP - 1) : '0;

  logic r_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else if (ld_valid && ((ld_addr & MIS_MASK) != '0)) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_err = r_misalign;
`endif

endmodule
